// File: rtl/ram_bist_pkg.sv
// ram_bist shared types and LFSR step function.
// Used by the BIST master top level and its LFSR.
package ram_bist_pkg;

  localparam logic [7:0] LFSR_TAPS = 8'hB8;

  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    READ,
    CHECK,
    DONE
  } state_t;

  function automatic logic [7:0] lfsr_next(
    input logic [7:0] v
  );
    return {v[6:0], ^(v & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/ram_bist_lfsr.sv
// ram_bist pattern generator: loadable Fibonacci LFSR.
// A zero seed is replaced by 1 so the value never sticks at 0.
module ram_bist_lfsr
  import ram_bist_pkg::*;
#(
  parameter int w = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         adv,
  input  logic [w-1:0] seed,
  output logic [w-1:0] value
);

  // load has priority over advance
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      value <= w'(1);
    end else if (load) begin
      value <= (seed == '0) ? w'(1) : seed;
    end else if (adv) begin
      value <= lfsr_next(value);
    end
  end

endmodule

// File: rtl/ram_bist_master.sv
// ram_bist_master: writes an LFSR pattern over a RAM range,
// reads it back and reports pass, error count, first bad address.
module ram_bist_master
  import ram_bist_pkg::*;
#(
  parameter int w        = 8,
  parameter int d        = 16,
  parameter int addr_len = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [addr_len-1:0] begin_addr,
  input  logic [addr_len:0]   end_addr,
  input  logic [w-1:0]        seed,
  output logic                valid,
  output logic                wrd,
  output logic [addr_len:0]   address,
  output logic [w-1:0]        wdata,
  input  logic                ready,
  input  logic [w-1:0]        rdata,
  output logic                busy,
  output logic                done,
  output logic                pass,
  output logic [addr_len:0]   err_count,
  output logic [addr_len:0]   first_err_addr
);

  localparam logic [addr_len:0] DEPTH = d[addr_len:0];

  state_t            state;
  logic [addr_len:0] begin_q;
  logic [addr_len:0] end_q;
  logic [w-1:0]      seed_q;

  logic              lfsr_load;
  logic              lfsr_adv;
  logic [w-1:0]      lfsr_seed;
  logic [w-1:0]      lfsr_val;

  logic [addr_len:0] begin_ext;
  logic [addr_len:0] end_clamp;
  logic              accept;
  logic              last_addr;
  logic              mismatch;

  assign begin_ext = {1'b0, begin_addr};
  assign end_clamp = (end_addr > DEPTH) ? DEPTH : end_addr;
  assign accept    = valid && ready;
  assign last_addr = (address == end_q - 1'b1);
  assign mismatch  = (rdata != lfsr_val);
  assign wdata     = wrd ? lfsr_val : '0;

  ram_bist_lfsr #(
    .w(w)
  ) u_lfsr (
    .clk  (clk),
    .rst  (rst),
    .load (lfsr_load),
    .adv  (lfsr_adv),
    .seed (lfsr_seed),
    .value(lfsr_val)
  );

  // one LFSR serves both passes: seeded on start, reseeded after last write
  always_comb begin
    lfsr_load = 1'b0;
    lfsr_adv  = 1'b0;
    lfsr_seed = seed_q;
    unique case (state)
      IDLE: begin
        lfsr_load = start;
        lfsr_seed = seed;
      end
      WRITE: begin
        lfsr_load = accept && last_addr;
        lfsr_adv  = accept && !last_addr;
      end
      CHECK: lfsr_adv = 1'b1;
      default: ;
    endcase
  end

  // sequencer, address counter and result registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      valid          <= 1'b0;
      wrd            <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
      pass           <= 1'b0;
      err_count      <= '0;
      first_err_addr <= '0;
      address        <= '0;
      begin_q        <= '0;
      end_q          <= '0;
      seed_q         <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            begin_q        <= begin_ext;
            end_q          <= end_clamp;
            seed_q         <= seed;
            address        <= begin_ext;
            err_count      <= '0;
            first_err_addr <= '0;
            pass           <= 1'b1;
            busy           <= 1'b1;
            if (end_clamp <= begin_ext) begin
              state <= DONE;
            end else begin
              state <= WRITE;
              valid <= 1'b1;
              wrd   <= 1'b1;
            end
          end
        end
        WRITE: begin
          if (accept) begin
            if (last_addr) begin
              address <= begin_q;
              wrd     <= 1'b0;
              state   <= READ;
            end else begin
              address <= address + 1'b1;
            end
          end
        end
        READ: begin
          if (accept) begin
            valid <= 1'b0;
            state <= CHECK;
          end
        end
        CHECK: begin
          if (mismatch) begin
            pass <= 1'b0;
            if (err_count != DEPTH) begin
              err_count <= err_count + 1'b1;
            end
            if (err_count == '0) begin
              first_err_addr <= address;
            end
          end
          if (last_addr) begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= DONE;
          end else begin
            address <= address + 1'b1;
            valid   <= 1'b1;
            state   <= READ;
          end
        end
        DONE: begin
          // empty runs arrive with done low and pulse it here
          if (done) begin
            done  <= 1'b0;
            state <= IDLE;
          end else begin
            done <= 1'b1;
            busy <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
